// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares one external combinational ALU between two requesters. Each
// accepted operation goes through IDLE -> EXEC -> RESP. The operands are
// captured on accept, the ALU output is latched during EXEC, and the result
// is held in RESP until the owning requester takes it. Ties in IDLE go to
// the requester that was not granted last.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   req<i>_valid/_ready        operation handshake for requester i
//   req<i>_a, req<i>_b         operands (WIDTH bits)
//   req<i>_op                  ALU control code (OPW bits)
//   rsp<i>_valid/_ready        result handshake for requester i
//   rsp<i>_result, rsp<i>_zero registered ALU result and zero flag
//   alu_srcA, alu_srcB         captured operands driven to the shared ALU
//   alu_ctrl                   captured control code driven to the ALU
//   alu_result, alu_zero       outputs of the shared ALU
//   busy                       high whenever an operation is in flight
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_result,
    output logic             rsp0_zero,

    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_result,
    output logic             rsp1_zero,

    output logic [WIDTH-1:0] alu_srcA,
    output logic [WIDTH-1:0] alu_srcB,
    output logic [OPW-1:0]   alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,

    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic             last_grant;
    logic             owner;
    logic             grant;
    logic             accept;

    logic [WIDTH-1:0] a_p0;
    logic [WIDTH-1:0] b_p0;
    logic [OPW-1:0]   op_p0;
    logic [WIDTH-1:0] result_p1;
    logic             zero_p1;

    // Round-robin pick: a lone requester wins outright; on a tie the one
    // that did not win last time goes. With nobody valid the value is unused.
    always_comb begin
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else begin
            grant = req1_valid;
        end
    end

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    req0_ready = ~grant;
                    req1_ready = grant;
                    accept     = 1'b1;
                    state_nxt  = EXEC;
                end
            end
            EXEC: begin
                state_nxt = RESP;
            end
            RESP: begin
                rsp0_valid = ~owner;
                rsp1_valid = owner;
                // Only the owner's ready matters; the other one is ignored.
                if (owner ? rsp1_ready : rsp0_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            a_p0       <= '0;
            b_p0       <= '0;
            op_p0      <= '0;
            result_p1  <= '0;
            zero_p1    <= 1'b0;
        end else begin
            state <= state_nxt;
            // Stage p0: operand capture on accept
            if (accept) begin
                owner      <= grant;
                last_grant <= grant;
                a_p0       <= grant ? req1_a  : req0_a;
                b_p0       <= grant ? req1_b  : req0_b;
                op_p0      <= grant ? req1_op : req0_op;
            end
            // Stage p1: ALU result latch during EXEC
            if (state == EXEC) begin
                result_p1 <= alu_result;
                zero_p1   <= alu_zero;
            end
        end
    end

    assign alu_srcA    = a_p0;
    assign alu_srcB    = b_p0;
    assign alu_ctrl    = op_p0;

    assign rsp0_result = result_p1;
    assign rsp0_zero   = zero_p1;
    assign rsp1_result = result_p1;
    assign rsp1_zero   = zero_p1;

    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

    localparam int WIDTH = 32;
    localparam int OPW   = 3;

    logic             clk;
    logic             rst_n;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [OPW-1:0]   req0_op, req1_op;
    logic             rsp0_valid, rsp1_valid;
    logic             rsp0_ready, rsp1_ready;
    logic [WIDTH-1:0] rsp0_result, rsp1_result;
    logic             rsp0_zero, rsp1_zero;
    logic [WIDTH-1:0] alu_srcA, alu_srcB, alu_result;
    logic [OPW-1:0]   alu_ctrl;
    logic             alu_zero;
    logic             busy;

    int checks = 0;
    int errors = 0;

    // Requester-side stimulus state
    logic             v     [2];
    logic [WIDTH-1:0] a     [2];
    logic [WIDTH-1:0] b     [2];
    logic [OPW-1:0]   op    [2];
    logic             rsp_r [2];

    // Reference model state: who won last (1 after reset, so req0 wins first tie)
    logic             last_m;
    // What a requester does once accepted: 0 keep requesting, 1 drop, 2 random
    int               mode;

    alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
        .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] alu_ref(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic [OPW-1:0] c);
        case (c)
            3'b000:  return x + y;
            3'b001:  return x - y;
            3'b010:  return x & y;
            3'b011:  return x | y;
            3'b100:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            3'b101:  return x << y[4:0];
            3'b110:  return x >> y[4:0];
            default: return $unsigned($signed(x) >>> y[4:0]);
        endcase
    endfunction

    // The shared ALU lives in the bench
    always_comb begin
        alu_result = alu_ref(alu_srcA, alu_srcB, alu_ctrl);
        alu_zero   = (alu_result == '0);
    end

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        req0_valid = v[0];  req0_a = a[0];  req0_b = b[0];  req0_op = op[0];
        req1_valid = v[1];  req1_a = a[1];  req1_b = b[1];  req1_op = op[1];
        rsp0_ready = rsp_r[0];
        rsp1_ready = rsp_r[1];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n  = 1'b1;
        last_m = 1'b1;
    endtask

    task automatic new_op(input int i);
        a[i]  = $urandom;
        b[i]  = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40));
        op[i] = 3'($urandom_range(0, 7));
    endtask

    // One transaction from IDLE back to IDLE, checked cycle by cycle against
    // the round-robin rule and the ALU definition. stall = cycles the owner
    // holds rsp_ready low once the response is up.
    task automatic run_txn(input int stall);
        int               g;
        logic [WIDTH-1:0] ea, eb, er, seen;
        logic [OPW-1:0]   eop;
        drive();
        #1;
        if (!v[0] && !v[1]) begin
            chk("idle_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
            chk("idle_busy", busy, 0);
            tick();
            return;
        end
        if (v[0] && v[1]) g = last_m ? 0 : 1;
        else              g = v[1] ? 1 : 0;
        chk("grant", {30'd0, req1_ready, req0_ready}, (g == 1) ? 32'd2 : 32'd1);
        chk("busy_c0", busy, 0);
        ea = a[g]; eb = b[g]; eop = op[g];
        er = alu_ref(ea, eb, eop);
        tick();
        last_m = g[0];
        if (mode == 1) v[g] = 1'b0;
        else if (mode == 2) begin
            v[g] = ($urandom_range(0, 3) != 0);
            new_op(g);
        end
        drive();
        #1;
        // EXEC cycle
        chk("busy_c1", busy, 1);
        chk("ready_exec", {30'd0, req1_ready, req0_ready}, 32'd0);
        chk("rspv_exec", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        chk("srcA", alu_srcA, ea);
        chk("srcB", alu_srcB, eb);
        chk("ctrl", alu_ctrl, eop);
        seen = alu_result;
        tick();
        rsp_r[g]     = 1'b0;
        rsp_r[1 - g] = ($urandom_range(0, 1) != 0);
        drive();
        #1;
        for (int k = 0; k <= stall; k++) begin
            if (k == stall) begin
                rsp_r[g] = 1'b1;
                drive();
                #1;
            end
            chk("rspv", {30'd0, rsp1_valid, rsp0_valid}, (g == 1) ? 32'd2 : 32'd1);
            chk("result", (g == 1) ? rsp1_result : rsp0_result, er);
            chk("result_alu", (g == 1) ? rsp1_result : rsp0_result, seen);
            chk("zero", (g == 1) ? rsp1_zero : rsp0_zero, (er == 0) ? 32'd1 : 32'd0);
            chk("busy_resp", busy, 1);
            chk("ready_resp", {30'd0, req1_ready, req0_ready}, 32'd0);
            tick();
        end
        // Back in IDLE
        chk("busy_done", busy, 0);
        chk("rspv_done", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        mode  = 1;
        for (int i = 0; i < 2; i++) begin
            v[i] = 1'b0; a[i] = '0; b[i] = '0; op[i] = '0; rsp_r[i] = 1'b0;
        end
        drive();

        // Reset state
        do_reset();
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        chk("rst_rspv", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        chk("rst_srcA", alu_srcA, 0);
        chk("rst_ctrl", alu_ctrl, 0);
        chk("rst_result", rsp0_result, 0);

        // 5 + 3 on req0
        v[0] = 1'b1; a[0] = 32'd5; b[0] = 32'd3; op[0] = 3'b000;
        run_txn(0);

        // Continuous contention from reset: grants 0,1,0
        do_reset();
        mode = 0;
        v[0] = 1'b1; a[0] = 32'd7;    b[0] = 32'd7;    op[0] = 3'b001;
        v[1] = 1'b1; a[1] = 32'hF0;   b[1] = 32'h0F;   op[1] = 3'b011;
        run_txn(0);
        chk("order_0", {31'd0, last_m}, 0);
        run_txn(0);
        chk("order_1", {31'd0, last_m}, 1);
        run_txn(0);
        chk("order_2", {31'd0, last_m}, 0);

        // Owner stalls 5 cycles with the other requester waiting
        run_txn(5);

        // sra on req1 alone
        mode = 1;
        v[0] = 1'b0;
        v[1] = 1'b1; a[1] = 32'h8000_0000; b[1] = 32'd4; op[1] = 3'b111;
        run_txn(0);

        // Reset during RESP aborts the response; next tie goes to req0
        do_reset();
        v[1] = 1'b1; a[1] = 32'd1; b[1] = 32'd2; op[1] = 3'b000;
        rsp_r[0] = 1'b0; rsp_r[1] = 1'b0;
        drive();
        #1;
        chk("abort_grant", {30'd0, req1_ready, req0_ready}, 32'd2);
        tick();
        tick();
        chk("abort_rspv", {31'd0, rsp1_valid}, 1);
        rst_n = 1'b0;
        tick();
        rst_n  = 1'b1;
        last_m = 1'b1;
        chk("abort_rspv_off", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        chk("abort_busy", busy, 0);
        v[0] = 1'b1; a[0] = 32'd9; b[0] = 32'd4; op[0] = 3'b110;
        run_txn(0);
        v[0] = 1'b0; v[1] = 1'b0;

        // Randomized traffic
        mode = 2;
        for (int r = 0; r < 60; r++) begin
            for (int i = 0; i < 2; i++) begin
                if (!v[i] && ($urandom_range(0, 2) != 0)) begin
                    v[i] = 1'b1;
                    new_op(i);
                end
            end
            run_txn(int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, the operand/result width in bits.
REQ-002 The block SHALL have parameter OPW, default 3, the ALU control code width in bits.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 For each i in {0,1}, the block SHALL have port req<i>_valid  input  1  requester i presents an operation.
REQ-006 For each i, the block SHALL have port req<i>_ready  output  1  the operation is accepted this cycle.
REQ-007 For each i, the block SHALL have ports req<i>_a and req<i>_b  input  WIDTH  operands A and B.
REQ-008 For each i, the block SHALL have port req<i>_op  input  OPW  ALU control code: 000 add, 001 sub, 010 and, 011 or, 100 slt, 101 sll, 110 srl, 111 sra.
REQ-009 For each i, the block SHALL have port rsp<i>_valid  output  1  a result for requester i is presented.
REQ-010 For each i, the block SHALL have port rsp<i>_ready  input  1  requester i consumes the result.
REQ-011 For each i, the block SHALL have ports rsp<i>_result  output  WIDTH and rsp<i>_zero  output  1, the registered ALU result and zero flag.
REQ-012 The block SHALL have ports alu_srcA and alu_srcB  output  WIDTH, and alu_ctrl  output  OPW, which drive the shared combinational ALU.
REQ-013 The block SHALL have ports alu_result  input  WIDTH and alu_zero  input  1, the ALU outputs.
REQ-014 The block SHALL have port busy  output  1, high whenever state is not IDLE.

Function
REQ-015 The block SHALL use the FSM states IDLE, EXEC and RESP.
REQ-016 IDLE: grant = the single valid requester; if both are valid, grant = the requester not in last_grant; req<grant>_ready = 1 combinationally; all other ready outputs = 0.
REQ-017 IDLE accept (valid & ready): capture a, b, op and the owner into registers; last_grant <= owner; next state EXEC.
REQ-018 IDLE with no valid requester: stay IDLE; no register change.
REQ-019 req<i>_ready SHALL be 0 in EXEC and RESP.
REQ-020 alu_srcA, alu_srcB and alu_ctrl SHALL always equal the captured registers; the block SHALL not pass requester inputs straight through to the ALU.
REQ-021 EXEC lasts exactly one cycle: latch alu_result/alu_zero into the result registers; next state RESP.
REQ-022 RESP: rsp<owner>_valid = 1 and the other rsp valid = 0; result and zero are held stable until the handshake.
REQ-023 RESP with rsp<owner>_ready = 1: next state IDLE.
REQ-024 RESP with rsp<owner>_ready = 0: remain in RESP indefinitely.
REQ-025 rsp_ready of the non-owner SHALL be ignored.
REQ-026 rsp<i>_result and rsp<i>_zero SHALL both be driven from the shared result registers; they are meaningful only while rsp<i>_valid is high.
REQ-027 Latency: accept edge N -> result latched at edge N+1 -> rsp_valid high from cycle N+2.
REQ-028 Minimum spacing between accepts is 3 cycles.
REQ-029 Under continuous contention, grants SHALL alternate 0,1,0,1; no requester is starved.
REQ-030 A requester SHALL hold valid and operands stable until accepted; a valid dropped before acceptance is simply not granted.
REQ-031 Widths: results pass through unmodified from the ALU; the block performs no arithmetic on operands.

Reset
REQ-032 While rst_n = 0 at a rising clk edge: state <= IDLE, last_grant <= 1 (so req0 wins the first tie), and operand, op and result registers <= 0.
REQ-033 After reset, all ready and rsp valid outputs SHALL be 0 except as IDLE grant logic dictates; busy = 0.
REQ-034 Reset asserted in EXEC or RESP SHALL abort the in-flight operation; no response is ever issued for it.

Verification
REQ-035 Reset, then req0 {a=5, b=3, op=000} with rsp0_ready = 1 -> req0_ready in cycle 0, rsp0_valid in cycle 2 with result 8 and zero 0, busy high for cycles 1-2.
REQ-036 Both requesters valid continuously, req0 sub 7-7 and req1 or 0xF0|0x0F -> grants in order 0,1,0; rsp0 = 0 with zero = 1; rsp1 = 0xFF.
REQ-037 rsp1_ready held 0 for 5 cycles after rsp1_valid -> rsp1_valid and the result stay stable, no new accept occurs, and IDLE is resumed the cycle after ready.
REQ-038 Shift check, req1 sra a=0x80000000 b=4 -> alu_ctrl = 111 during EXEC and rsp1_result equals the ALU output driven by the bench.
REQ-039 rst_n pulsed low during RESP -> rsp_valid = 0 the next cycle, state IDLE, and the next tie goes to req0.
